pipe_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage (IF/ID/EX/MEM/WB) pipelined version of the 64-bit LEGv8 CPU. It keeps its own shadow copy of the destination and source register fields held in the ID/EX, EX/MEM and MEM/WB registers. From that copy it produces:
- PC and IF/ID write enables;
- ID/EX bubble insertion and IF/ID flush;
- ALU operand forwarding selects;
- saturating stall and flush statistics counters.

It sits beside the pipeline registers, between the control unit / register-bank decode path and the ALU input muxes.

---
 rtl/pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage LEGv8 pipeline.
// Keeps shadow ID/EX, EX/MEM, MEM/WB register-field records and drives stall, flush and forward controls.
module pipe_hazard_ctrl #(
    parameter int NREG_BITS = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NREG_BITS-1:0] id_rs1,
    input  logic [NREG_BITS-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 ex_take_branch,
    input  logic                 mem_busy,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [NREG_BITS-1:0] XZR     = {NREG_BITS{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // EX record
    logic                 ex_v_q,    ex_v_d;
    logic [NREG_BITS-1:0] ex_rs1_q,  ex_rs1_d;
    logic [NREG_BITS-1:0] ex_rs2_q,  ex_rs2_d;
    logic                 ex_use1_q, ex_use1_d;
    logic                 ex_use2_q, ex_use2_d;
    logic [NREG_BITS-1:0] ex_rd_q,   ex_rd_d;
    logic                 ex_rw_q,   ex_rw_d;
    logic                 ex_mr_q,   ex_mr_d;
    // MEM and WB records
    logic                 mem_v_q,   mem_v_d;
    logic [NREG_BITS-1:0] mem_rd_q,  mem_rd_d;
    logic                 mem_rw_q,  mem_rw_d;
    logic                 wb_v_q,    wb_v_d;
    logic [NREG_BITS-1:0] wb_rd_q,   wb_rd_d;
    logic                 wb_rw_q,   wb_rw_d;
    // statistics
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic lu_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_bubble_s;
    logic stall_evt_s;
    logic flush_evt_s;

    // A record is a producer for rs only if it is live, writes, and its target is not XZR.
    function automatic logic src_match(
        input logic                 v,
        input logic                 rw,
        input logic [NREG_BITS-1:0] rd,
        input logic [NREG_BITS-1:0] rs
    );
        return v & rw & (rd != XZR) & (rd == rs);
    endfunction

    // Newest producer wins: EX/MEM ALUOut over MEM/WB write data.
    function automatic logic [1:0] fwd_sel(
        input logic                 ex_v,
        input logic                 use_op,
        input logic [NREG_BITS-1:0] rs
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v & use_op) begin
            if (src_match(mem_v_q, mem_rw_q, mem_rd_q, rs)) begin
                sel = 2'b10;
            end else if (src_match(wb_v_q, wb_rw_q, wb_rd_q, rs)) begin
                sel = 2'b01;
            end else begin
                sel = 2'b00;
            end
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use hazard between the ID reader and a load sitting in EX.
    always_comb begin
        lu_s = id_valid & ex_v_q & ex_mr_q & (ex_rd_q != XZR) &
               ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));
    end

    // Prioritised pipeline control; reset forces the safe "squash everything" pattern.
    always_comb begin
        pc_write_s    = 1'b0;
        ifid_write_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        stall_evt_s   = 1'b0;
        flush_evt_s   = 1'b0;
        if (!reset) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (mem_busy) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
        end else if (ex_take_branch) begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            flush_evt_s   = 1'b1;
        end else if (lu_s) begin
            idex_bubble_s = 1'b1;
            stall_evt_s   = 1'b1;
        end else begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
        end
    end

    // Next-state for records and counters; a busy data memory freezes everything.
    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_use1_d   = ex_use1_q;
        ex_use2_d   = ex_use2_q;
        ex_rd_d     = ex_rd_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        mem_v_d     = mem_v_q;
        mem_rd_d    = mem_rd_q;
        mem_rw_d    = mem_rw_q;
        wb_v_d      = wb_v_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_busy) begin
            wb_v_d    = mem_v_q;
            wb_rd_d   = mem_rd_q;
            wb_rw_d   = mem_rw_q;
            mem_v_d   = ex_v_q;
            mem_rd_d  = ex_rd_q;
            mem_rw_d  = ex_rw_q;
            ex_v_d    = id_valid & ~idex_bubble_s;
            ex_rs1_d  = id_rs1;
            ex_rs2_d  = id_rs2;
            ex_use1_d = id_use_rs1 & ~idex_bubble_s;
            ex_use2_d = id_use_rs2 & ~idex_bubble_s;
            ex_rd_d   = id_rd;
            ex_rw_d   = id_regwrite & ~idex_bubble_s;
            ex_mr_d   = id_memread & ~idex_bubble_s;
            if (stall_evt_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_evt_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Record and counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v_q      <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_use1_q   <= ex_use1_d;
            ex_use2_q   <= ex_use2_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_write    = pc_write_s;
    assign ifid_write  = ifid_write_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign fwd_a       = fwd_sel(ex_v_q, ex_use1_q, ex_rs1_q);
    assign fwd_b       = fwd_sel(ex_v_q, ex_use2_q, ex_rs2_q);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (CNT_W=2 so counter saturation is reachable).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_take_branch;
    logic       mem_busy;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    int n_cmp;
    int n_err;

    pipe_hazard_ctrl #(.NREG_BITS(5), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pcw, input logic ifw, input logic fl, input logic bub);
        check_val({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
        check_val({tag, ".ifid_write"}, 32'(ifid_write), 32'(ifw));
        check_val({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
        check_val({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check_val({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
        check_val({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] s, input logic [1:0] f);
        check_val({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(s));
        check_val({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(f));
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic br, input logic busy);
        id_valid       = v;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_use_rs1     = u1;
        id_use_rs2     = u2;
        id_rd          = rd;
        id_regwrite    = rw;
        id_memread     = mr;
        ex_take_branch = br;
        mem_busy       = busy;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            nop();
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        nop();
        #2;
        chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_fwd("rst", 2'b00, 2'b00);
        chk_cnt("rst", 2'd0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD X1<-X2,X3 ; SUB X4<-X1,X5
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("alu.add", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("alu.sub_id", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        @(negedge clk);
        chk_fwd("alu.sub_ex", 2'b10, 2'b00);
        chk_ctl("alu.sub_ex", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("alu.stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        idle(3);

        // LDUR X1 ; ADD X2<-X1,X1
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("lu.stall", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        chk_ctl("lu.release", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("lu.stall_cnt", 32'(stall_cnt), 32'd1);
        step();
        nop();
        @(negedge clk);
        chk_fwd("lu.ex", 2'b01, 2'b01);
        step();
        idle(3);

        // taken branch hides a simultaneous load-use
        drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_ctl("br.take", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cnt("br.cnt", 2'd1, 2'd1);
        chk_fwd("br.ex1", 2'b00, 2'b00);
        chk_ctl("br.after", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        @(negedge clk);
        chk_fwd("br.ex2", 2'b00, 2'b00);
        step();
        idle(3);

        // XZR never hazards or forwards
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("xzr.id", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        @(negedge clk);
        chk_fwd("xzr.ex", 2'b00, 2'b00);
        step();
        idle(3);

        // MEM and WB both write X7; the LDUR X8 reading X7 takes MEM
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        // memory busy 3 cycles while a reader of X8 waits in ID
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk_ctl($sformatf("busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk_fwd($sformatf("busy%0d", i), 2'b10, 2'b00);
            chk_cnt($sformatf("busy%0d", i), 2'd1, 2'd1);
            step();
        end
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("busy.resume", 1'b0, 1'b0, 1'b0, 1'b1);
        chk_fwd("busy.resume", 2'b10, 2'b00);
        step();
        @(negedge clk);
        chk_ctl("busy.release", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("busy.stall_cnt", 32'(stall_cnt), 32'd2);
        step();
        nop();
        @(negedge clk);
        chk_fwd("busy.ex", 2'b01, 2'b00);
        step();
        idle(3);

        // three more load-use stalls: 5 total saturates a 2-bit counter at 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
            drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk_ctl($sformatf("sat%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            step();
            idle(2);
        end
        chk_cnt("sat", 2'd3, 2'd1);

        // reset asserted in the middle of a stall
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("mid.stall", 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk_ctl("mid.rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_fwd("mid.rst", 2'b00, 2'b00);
        chk_cnt("mid.rst", 2'd0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk_ctl("post.rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_fwd("post.rst", 2'b00, 2'b00);
        step();
        nop();
        @(negedge clk);
        chk_fwd("post.ex", 2'b00, 2'b00);
        chk_cnt("post.cnt", 2'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
